// File: rtl/rr_issue_scheduler_pkg.sv
// rr_issue_scheduler_pkg: shared widths and slot type for the round-robin issue scheduler.
package rr_issue_scheduler_pkg;
    localparam int DEF_ITEM_NUM   = 8;
    localparam int DEF_GRANT_NUM  = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int ITEM_ID_W      = $clog2(DEF_ITEM_NUM);
    localparam int CNT_W          = ITEM_ID_W + 1;

    typedef struct packed {
        logic                      valid;
        logic [DEF_DATA_WIDTH-1:0] data;
    } slot_t;
endpackage

// File: rtl/list_enabled_item_id.sv
// list_enabled_item_id: ids of set bits in seq, ordered circularly from start_pos.
module list_enabled_item_id #(
    parameter int ITEM_NUM = 8,
    parameter int LIST_NUM = ITEM_NUM,
    localparam int IW      = $clog2(ITEM_NUM)
) (
    input  logic [ITEM_NUM-1:0]          seq,
    input  logic [IW-1:0]                start_pos,
    output logic [LIST_NUM-1:0][IW-1:0]  list
);
    logic [IW-1:0] pos;
    int            found;

    // ITEM_NUM is a power of two, so the IW-bit add wraps naturally
    always_comb begin
        list  = '0;
        pos   = '0;
        found = 0;
        for (int i = 0; i < ITEM_NUM; i++) begin
            pos = start_pos + IW'(i);
            if (seq[pos]) begin
                for (int k = 0; k < LIST_NUM; k++)
                    if (found == k) list[k] = pos;
                found++;
            end
        end
    end
endmodule

// File: rtl/priority_finder.sv
// priority_finder: index of the lowest (FIRST_PRIORITY 0) or highest set request bit.
module priority_finder #(
    parameter int WIDTH          = 8,
    parameter int FIRST_PRIORITY = 0,
    localparam int IW            = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IW-1:0]    idx,
    output logic             found
);
    // the last match written wins, so scan direction picks the priority end
    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (FIRST_PRIORITY == 0 && req[i]) idx = IW'(i);
        for (int i = 0; i < WIDTH; i++)
            if (FIRST_PRIORITY != 0 && req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/rr_issue_scheduler.sv
// rr_issue_scheduler: slot buffer issuing up to GRANT_NUM entries per cycle in round-robin order.
module rr_issue_scheduler
    import rr_issue_scheduler_pkg::*;
#(
    parameter int ITEM_NUM   = DEF_ITEM_NUM,
    parameter int GRANT_NUM  = DEF_GRANT_NUM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    output logic [GRANT_NUM-1:0]                  out_valid,
    output logic [GRANT_NUM-1:0][ITEM_ID_W-1:0]   out_id,
    output logic [GRANT_NUM-1:0][DATA_WIDTH-1:0]  out_data,
    input  logic                                  out_ready,
    output logic [ITEM_ID_W-1:0]                  ptr_o
);
    slot_t                               slots [ITEM_NUM];
    logic [ITEM_NUM-1:0]                 valid, clr;
    logic [ITEM_ID_W-1:0]                ptr, wr_id, last_id;
    logic [GRANT_NUM-1:0][ITEM_ID_W-1:0] order;
    logic [CNT_W-1:0]                    cnt, g;
    logic                                free_found, issue;

    always_comb begin
        valid = '0;
        cnt   = '0;
        for (int i = 0; i < ITEM_NUM; i++) begin
            valid[i] = slots[i].valid;
            cnt      = cnt + CNT_W'(slots[i].valid);
        end
        g = (cnt > CNT_W'(GRANT_NUM)) ? CNT_W'(GRANT_NUM) : cnt;
    end

    list_enabled_item_id #(.ITEM_NUM(ITEM_NUM), .LIST_NUM(GRANT_NUM)) u_list (
        .seq(valid),
        .start_pos(ptr),
        .list(order)
    );

    priority_finder #(.WIDTH(ITEM_NUM), .FIRST_PRIORITY(0)) u_free (
        .req(~valid),
        .idx(wr_id),
        .found(free_found)
    );

    always_comb begin
        out_valid = '0;
        out_id    = '0;
        out_data  = '0;
        clr       = '0;
        last_id   = '0;
        for (int k = 0; k < GRANT_NUM; k++) begin
            out_valid[k] = (CNT_W'(k) < g) && !flush;
            if (out_valid[k]) begin
                out_id[k]       = order[k];
                out_data[k]     = slots[order[k]].data;
                clr[order[k]]   = 1'b1;
                last_id         = order[k];
            end
        end
    end

    assign issue    = out_ready && |out_valid;
    assign in_ready = free_found && !flush;
    assign ptr_o    = ptr;

    // the write slot comes from the pre-issue free set, so it never overlaps clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < ITEM_NUM; i++) slots[i] <= '0;
        end else if (flush) begin
            ptr <= '0;
            for (int i = 0; i < ITEM_NUM; i++) slots[i].valid <= 1'b0;
        end else begin
            if (issue) begin
                ptr <= last_id + 1'b1;
                for (int i = 0; i < ITEM_NUM; i++)
                    if (clr[i]) slots[i].valid <= 1'b0;
            end
            if (in_valid && in_ready) slots[wr_id] <= '{valid: 1'b1, data: in_data};
        end
    end
endmodule

// File: tb/tb_rr_issue_scheduler.sv
// tb_rr_issue_scheduler: directed vectors for the round-robin issue scheduler.
module tb_rr_issue_scheduler;
    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_ready;
    logic [31:0]      in_data;
    logic [1:0]       out_valid;
    logic [1:0][2:0]  out_id;
    logic [1:0][31:0] out_data;
    logic [2:0]       ptr_o;
    int               n_vec = 0;
    int               n_miss = 0;

    rr_issue_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
        .out_ready(out_ready), .ptr_o(ptr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [1:0] ov, input logic [2:0] i0, input logic [2:0] i1,
                         input logic [31:0] d0, input logic [31:0] d1);
        check({tag, ".ov"}, 64'(out_valid), 64'(ov));
        check({tag, ".id0"}, 64'(out_id[0]), 64'(i0));
        check({tag, ".id1"}, 64'(out_id[1]), 64'(i1));
        check({tag, ".d0"}, 64'(out_data[0]), 64'(d0));
        check({tag, ".d1"}, 64'(out_data[1]), 64'(d1));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk_g("rst", 2'b00, 0, 0, 0, 0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.ptr", 64'(ptr_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        chk_g("idle", 2'b00, 0, 0, 0, 0);
        check("idle.in_ready", 64'(in_ready), 64'd1);
        check("idle.ptr", 64'(ptr_o), 64'd0);

        for (int i = 0; i < 5; i++) push(32'hA0 + 32'(i));
        out_ready = 1'b1;
        #1 chk_g("drain0", 2'b11, 0, 1, 32'hA0, 32'hA1);
        tick();
        chk_g("drain1", 2'b11, 2, 3, 32'hA2, 32'hA3);
        check("drain1.ptr", 64'(ptr_o), 64'd2);
        tick();
        chk_g("drain2", 2'b01, 4, 0, 32'hA4, 0);
        check("drain2.ptr", 64'(ptr_o), 64'd4);
        tick();
        out_ready = 1'b0;
        check("drain3.ov", 64'(out_valid), 64'd0);
        check("drain3.ptr", 64'(ptr_o), 64'd5);

        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        check("full.in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = 32'hE0; out_ready = 1'b1;
        #1 chk_g("full.g", 2'b11, 5, 6, 32'hD5, 32'hD6);
        check("full.in_ready2", 64'(in_ready), 64'd0);
        tick();
        check("wrap.in_ready", 64'(in_ready), 64'd1);
        check("wrap.ptr", 64'(ptr_o), 64'd7);
        chk_g("wrap", 2'b11, 7, 0, 32'hD7, 32'hD0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1 chk_g("hold0", 2'b11, 1, 2, 32'hD1, 32'hD2);
        check("hold0.ptr", 64'(ptr_o), 64'd1);
        tick();
        chk_g("hold1", 2'b11, 1, 2, 32'hD1, 32'hD2);
        check("hold1.ptr", 64'(ptr_o), 64'd1);
        out_ready = 1'b1;
        tick();
        chk_g("after_hold", 2'b11, 3, 4, 32'hD3, 32'hD4);
        check("after_hold.ptr", 64'(ptr_o), 64'd3);
        tick();
        chk_g("refill", 2'b01, 5, 0, 32'hE0, 0);
        check("refill.ptr", 64'(ptr_o), 64'd5);
        tick();
        out_ready = 1'b0;
        check("empty.ov", 64'(out_valid), 64'd0);
        check("empty.ptr", 64'(ptr_o), 64'd6);

        for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
        #1 chk_g("preflush", 2'b11, 0, 1, 32'hF0, 32'hF1);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hFF; out_ready = 1'b1;
        #1 chk_g("flush", 2'b00, 0, 0, 0, 0);
        check("flush.in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 check("postflush.ov", 64'(out_valid), 64'd0);
        check("postflush.ptr", 64'(ptr_o), 64'd0);
        check("postflush.in_ready", 64'(in_ready), 64'd1);
        push(32'h60);
        #1 chk_g("postflush.wr", 2'b01, 0, 0, 32'h60, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("postflush.ptr2", 64'(ptr_o), 64'd1);

        for (int i = 0; i < 6; i++) push(32'h70 + 32'(i));
        out_ready = 1'b1;
        #1 chk_g("mid", 2'b11, 1, 2, 32'h71, 32'h72);
        #1 rst = 1'b1;
        #1 chk_g("arst", 2'b00, 0, 0, 0, 0);
        check("arst.ptr", 64'(ptr_o), 64'd0);
        check("arst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b0;
        #1 check("arst.ov2", 64'(out_valid), 64'd0);
        push(32'h80);
        #1 chk_g("arst.wr", 2'b01, 0, 0, 32'h80, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
